// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read and write controllers: Gray/binary
// conversion and the depth/pointer-width consistency check.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH   = 4;
  localparam int FIFO_DEPTH_WIDTH = 16;
  localparam bit FIFO_DEPTH_OK    = (FIFO_DEPTH_WIDTH == (1 << FIFO_PTR_WIDTH));

  // Conversions work on a zero-extended word, so any pointer up to 32 bits
  // can use them by casting in and truncating the result back.
  localparam int GRAY_MAX_WIDTH = 32;
  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic bit depth_ok(input int ptrWidth, input int depthWidth);
    return depthWidth == (1 << ptrWidth);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = gray;
    for (int i = 1; i < GRAY_MAX_WIDTH; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             r_clk,
  input  logic             rreset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge r_clk) begin
    if (rreset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: pointer sync, empty/level flags,
// memory read issue and a two-entry AXI-Stream output buffer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PTR_WIDTH   = FIFO_PTR_WIDTH,
  parameter int DEPTH_WIDTH = FIFO_DEPTH_WIDTH
) (
  input  logic                  r_clk,
  input  logic                  rreset,
  input  logic                  flush,
  input  logic [PTR_WIDTH:0]    wq_wptr_gray,
  output logic [PTR_WIDTH:0]    rd_ptr_gray,
  output logic [PTR_WIDTH-1:0]  r_addr,
  output logic                  fifo_rd_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  empty,
  output logic                  fifo_empty,
  output logic [PTR_WIDTH:0]    rd_level
);

  localparam int PW = PTR_WIDTH + 1;

  if (!depth_ok(PTR_WIDTH, DEPTH_WIDTH)) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH_WIDTH must equal 2**PTR_WIDTH");
  end

  logic                  w_clear;
  logic [PW-1:0]         w_wq2WptrGray;
  logic [PW-1:0]         w_wbin;
  logic [PW-1:0]         w_rbinNext;
  logic [PW-1:0]         w_rgrayNext;
  logic                  w_pop;
  logic                  w_rdEnable;
  logic [2:0]            w_occupancy;

  logic [PW-1:0]         r_rbin;
  logic [PW-1:0]         r_rdPtrGray;
  logic [PW-1:0]         r_rdLevel;
  logic                  r_empty;
  logic                  r_inflight;
  logic [1:0]            r_outCnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  assign w_clear = rreset | flush;

  fifo_sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .r_clk  (r_clk),
    .rreset (w_clear),
    .d      (wq_wptr_gray),
    .q      (w_wq2WptrGray)
  );

  assign w_wbin = PW'(gray2bin(gray_word_t'(w_wq2WptrGray)));

  // Slots already committed (buffered or returning) minus this cycle's pop
  // must leave room for one more beat before a read may be issued.
  assign w_pop       = m_axis_tvalid & m_axis_tready;
  assign w_occupancy = {1'b0, r_outCnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rdEnable  = !w_clear && !r_empty && (w_occupancy < 3'd2);

  assign w_rbinNext  = r_rbin + {{PTR_WIDTH{1'b0}}, w_rdEnable};
  assign w_rgrayNext = PW'(bin2gray(gray_word_t'(w_rbinNext)));

  always_ff @(posedge r_clk) begin
    if (w_clear) begin
      r_rbin      <= '0;
      r_rdPtrGray <= '0;
      r_rdLevel   <= '0;
      r_empty     <= 1'b1;
      r_inflight  <= 1'b0;
    end else begin
      r_rbin      <= w_rbinNext;
      r_rdPtrGray <= w_rgrayNext;
      r_rdLevel   <= w_wbin - w_rbinNext;
      r_empty     <= (w_rgrayNext == w_wq2WptrGray);
      r_inflight  <= w_rdEnable;
    end
  end

  // Returning data lands in the head when it is free or draining, otherwise
  // in the skid; a pop with the skid occupied promotes the skid to the head.
  always_ff @(posedge r_clk) begin
    if (w_clear) begin
      r_outCnt <= 2'd0;
      r_head   <= '0;
      r_skid   <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_outCnt == 2'd0) begin
            r_head <= mem_data_out;
          end else begin
            r_skid <= mem_data_out;
          end
          r_outCnt <= r_outCnt + 2'd1;
        end
        2'b01: begin
          if (r_outCnt == 2'd2) begin
            r_head <= r_skid;
          end
          r_outCnt <= r_outCnt - 2'd1;
        end
        2'b11: begin
          if (r_outCnt == 2'd2) begin
            r_head <= r_skid;
            r_skid <= mem_data_out;
          end else begin
            r_head <= mem_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign r_addr         = r_rbin[PTR_WIDTH-1:0];
  assign fifo_rd_enable = w_rdEnable;
  assign rd_ptr_gray    = r_rdPtrGray;
  assign rd_level       = r_rdLevel;
  assign empty          = r_empty;
  assign m_axis_tvalid  = (r_outCnt != 2'd0);
  assign m_axis_tdata   = r_head;
  assign fifo_empty     = r_empty & !r_inflight & (r_outCnt == 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a counter/queue model of the read side
// predicts flags, pointers, level, read issue and stream beats every cycle.
module tb_fifo_rd_ctrl;

  localparam int DW        = 8;
  localparam int PW        = 5;
  localparam int MAX_EDGES = 4096;

  logic          r_clk = 1'b0;
  logic          rreset;
  logic          flush;
  logic [PW-1:0] wq_wptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic [3:0]    r_addr;
  logic          fifo_rd_enable;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          empty;
  logic          fifo_empty;
  logic [PW-1:0] rd_level;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(4), .DEPTH_WIDTH(16)) dut (
    .r_clk          (r_clk),
    .rreset         (rreset),
    .flush          (flush),
    .wq_wptr_gray   (wq_wptr_gray),
    .rd_ptr_gray    (rd_ptr_gray),
    .r_addr         (r_addr),
    .fifo_rd_enable (fifo_rd_enable),
    .mem_data_out   (mem_data_out),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .empty          (empty),
    .fifo_empty     (fifo_empty),
    .rd_level       (rd_level)
  );

  always #5 r_clk = ~r_clk;

  // Model state: counts since the last reset/flush, taken mod 2**PW.
  logic [DW-1:0] memArr [16];
  logic [DW-1:0] expQ [$];
  logic [PW-1:0] wHist [MAX_EDGES];
  logic [PW-1:0] wbin;
  logic [PW-1:0] issued;
  logic [PW-1:0] popped;
  logic [PW-1:0] arrived;
  bit            expEmpty;
  bit            expTvalid;
  int            edgeNum;
  int            clearEdge;
  int            dutReads;
  int            checkCnt;
  int            passCnt;
  int            failCnt;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] d);
    memArr[wbin[3:0]] = d;
    expQ.push_back(d);
    wbin = wbin + 1'b1;
    wq_wptr_gray = b2g(wbin);
  endtask

  // One clock: check the read issue and any beat, cross the edge, update the
  // model, feed the memory return and check every registered output.
  task automatic applyStimulus();
    bit            rstNow;
    bit            popNow;
    bit            expEn;
    bit            enNow;
    logic [3:0]    addrNow;
    logic [PW-1:0] vis;
    logic [PW-1:0] lvl;
    #1;
    rstNow = rreset | flush;
    popNow = !rstNow && expTvalid && m_axis_tready;
    expEn  = !rstNow && !expEmpty && (PW'(issued - popped - PW'(popNow)) < PW'(2));
    checkOutput("rd_enable", 32'(fifo_rd_enable), 32'(expEn));
    if (popNow && expQ.size() > 0) begin
      checkOutput("tdata", 32'(m_axis_tdata), 32'(expQ.pop_front()));
    end
    enNow   = fifo_rd_enable;
    addrNow = r_addr;
    if (enNow) dutReads++;
    wHist[edgeNum+1] = wbin;
    @(posedge r_clk);
    edgeNum++;
    if (rstNow) begin
      issued    = '0;
      popped    = '0;
      arrived   = '0;
      clearEdge = edgeNum;
      expQ.delete();
    end else begin
      arrived = issued;
      if (expEn) issued = issued + 1'b1;
      if (popNow) popped = popped + 1'b1;
    end
    #1;
    mem_data_out = enNow ? memArr[addrNow] : DW'($urandom);
    vis       = (edgeNum - 2 > clearEdge) ? wHist[edgeNum-2] : '0;
    lvl       = vis - issued;
    expEmpty  = (lvl == '0);
    expTvalid = (arrived != popped);
    checkOutput("empty", 32'(empty), 32'(expEmpty));
    checkOutput("rd_level", 32'(rd_level), 32'(lvl));
    checkOutput("rd_ptr_gray", 32'(rd_ptr_gray), 32'(b2g(issued)));
    checkOutput("r_addr", 32'(r_addr), 32'(issued[3:0]));
    checkOutput("tvalid", 32'(m_axis_tvalid), 32'(expTvalid));
    checkOutput("fifo_empty", 32'(fifo_empty), 32'(expEmpty && (issued == popped)));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    rreset = 1'b1;
    wbin   = '0;
    for (int i = 0; i < 2; i++) begin
      m_axis_tready = 1'($urandom);
      flush         = 1'($urandom);
      wq_wptr_gray  = PW'($urandom);
      applyStimulus();
    end
    checkOutput("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_fifo_empty", 32'(fifo_empty), 32'd1);
    checkOutput("reset_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    checkOutput("reset_r_addr", 32'(r_addr), 32'd0);
    checkOutput("reset_rd_level", 32'(rd_level), 32'd0);
    rreset        = 1'b0;
    flush         = 1'b0;
    wq_wptr_gray  = '0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int  base;
    bit  found;
    checkCnt = 0; passCnt = 0; failCnt = 0;
    edgeNum = 0; clearEdge = 0; dutReads = 0;
    issued = '0; popped = '0; arrived = '0; wbin = '0;
    expEmpty = 1'b1; expTvalid = 1'b0;
    rreset = 1'b1; flush = 1'b0; m_axis_tready = 1'b0;
    wq_wptr_gray = '0; mem_data_out = '0;
    for (int i = 0; i < 16; i++) memArr[i] = '0;

    // Reset, then a single beat with exact sync and issue latency.
    doReset();
    pushWord(8'hA5);
    applyStimulus();
    checkOutput("sync_empty_1", 32'(empty), 32'd1);
    applyStimulus();
    checkOutput("sync_empty_2", 32'(empty), 32'd1);
    applyStimulus();
    checkOutput("sync_empty_fall", 32'(empty), 32'd0);
    checkOutput("single_issue", 32'(fifo_rd_enable), 32'd1);
    checkOutput("single_addr", 32'(r_addr), 32'd0);
    runCycles(2);
    checkOutput("single_tvalid", 32'(m_axis_tvalid), 32'd1);
    checkOutput("single_tdata", 32'(m_axis_tdata), 32'hA5);
    runCycles(4);
    checkOutput("single_rd_ptr_gray", 32'(rd_ptr_gray), 32'b00001);
    checkOutput("single_empty", 32'(empty), 32'd1);

    // Full drain of 16 entries across the address wrap.
    doReset();
    for (int i = 0; i < 16; i++) begin
      memArr[i] = DW'($urandom);
      expQ.push_back(memArr[i]);
    end
    wbin = PW'(16);
    wq_wptr_gray = 5'b11000;
    runCycles(24);
    checkOutput("drain_rd_ptr_gray", 32'(rd_ptr_gray), 32'b11000);
    checkOutput("drain_rd_level", 32'(rd_level), 32'd0);
    checkOutput("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    pushWord(8'h5A);
    runCycles(8);
    checkOutput("wrap_rd_ptr_gray", 32'(rd_ptr_gray), 32'b11001);

    // Backpressure: only two reads outstanding, head held stable.
    doReset();
    m_axis_tready = 1'b0;
    base = dutReads;
    for (int i = 1; i <= 4; i++) begin
      pushWord(DW'(8'h11 * i));
      applyStimulus();
    end
    runCycles(10);
    checkOutput("bp_reads", 32'(dutReads - base), 32'd2);
    checkOutput("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    checkOutput("bp_tdata", 32'(m_axis_tdata), 32'h11);
    m_axis_tready = 1'b1;
    runCycles(8);
    checkOutput("bp_drained", 32'(m_axis_tvalid), 32'd0);
    for (int i = 0; i < 6; i++) pushWord(DW'($urandom));
    for (int i = 0; i < 24; i++) begin
      m_axis_tready = ~m_axis_tready;
      applyStimulus();
    end

    // Random writes and ready against the model.
    for (int i = 0; i < 300; i++) begin
      m_axis_tready = 1'($urandom);
      if ($urandom_range(1, 0) == 1 && PW'(wbin - issued) < PW'(16)) pushWord(DW'($urandom));
      applyStimulus();
    end
    m_axis_tready = 1'b1;
    runCycles(40);
    checkOutput("random_fifo_empty", 32'(fifo_empty), 32'd1);

    // Flush while a beat is presented and a read is returning.
    for (int i = 0; i < 8; i++) pushWord(DW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus();
      found = expTvalid && (issued != arrived);
    end
    checkOutput("flush_setup", 32'(found), 32'd1);
    m_axis_tready = 1'b0;
    flush         = 1'b1;
    wbin          = '0;
    wq_wptr_gray  = '0;
    applyStimulus();
    flush = 1'b0;
    checkOutput("flush_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("flush_rd_ptr_gray", 32'(rd_ptr_gray), 32'd0);
    checkOutput("flush_r_addr", 32'(r_addr), 32'd0);
    checkOutput("flush_fifo_empty", 32'(fifo_empty), 32'd1);
    m_axis_tready = 1'b1;
    runCycles(6);
    pushWord(8'h3C);
    runCycles(8);

    $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the async FIFO. It runs entirely in the read clock domain. It synchronizes the write pointer, computes empty and fill level, drives the read port of fifo_mem (r_addr, fifo_rd_enable), and converts the memory's 1-cycle registered read data into an AXI-Stream master interface with full valid/ready backpressure. It pairs with the write-side controller, which consumes rd_ptr_gray.

Parameters:
DATA_WIDTH, 8, stream and memory data width
PTR_WIDTH, 4, memory address bits; pointers are PTR_WIDTH+1 bits
DEPTH_WIDTH, 16, number of memory entries; must equal 2**PTR_WIDTH

Ports:
r_clk  in  1  read-domain clock
rreset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear in r_clk, asserted together with fifo_mem flush
wq_wptr_gray  in  PTR_WIDTH+1  Gray write pointer from write domain (asynchronous)
rd_ptr_gray  out  PTR_WIDTH+1  registered Gray read pointer to write domain
r_addr  out  PTR_WIDTH  fifo_mem read address
fifo_rd_enable  out  1  fifo_mem read strobe
mem_data_out  in  DATA_WIDTH  fifo_mem data_out, valid the cycle after fifo_rd_enable
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
empty  out  1  no unread entries in memory
fifo_empty  out  1  empty, no read in flight, and output buffer empty
rd_level  out  PTR_WIDTH+1  synchronized write binary minus read binary, modulo 2**(PTR_WIDTH+1)

Behaviour:
- Clocking and reset: all state is on posedge r_clk. rreset or flush forces the following values. Reset wins over all other inputs. Reset mid-stream discards buffered and in-flight data.
  - 0: rbin, the synchronizer flops, the output buffer, out_cnt, inflight, tvalid, tdata, rd_level, rd_ptr_gray, r_addr, fifo_rd_enable.
  - 1: empty, fifo_empty.
- Synchronization: wq_wptr_gray passes through a 2-flop synchronizer to produce wq2_wptr. wbin is gray2bin(wq2_wptr).
- Read pointer:
  - rbin is PTR_WIDTH+1 bits and increments by 1 on each fifo_rd_enable. It wraps naturally at 2**(PTR_WIDTH+1).
  - r_addr = rbin[PTR_WIDTH-1:0], combinational from the rbin register.
  - rd_ptr_gray is a register loaded with bin2gray(rbin_next).
- empty is registered: empty <= (bin2gray(rbin_next) == wq2_wptr).
- rd_level is registered: rd_level <= wbin - rbin_next.
- Output buffer:
  - Two entries: a head register and a skid register.
  - out_cnt ranges 0..2. inflight is 1 the cycle after fifo_rd_enable.
  - pop = tvalid & tready.
- Issue rule: fifo_rd_enable = !empty & (out_cnt + inflight - pop < 2).
  - fifo_rd_enable is combinational from registers and tready.
  - It never asserts while empty=1, so underflow is impossible.
- Capture rule: when inflight=1, mem_data_out is written into the buffer that cycle.
  - It goes to the head if the head is free or popping; otherwise to the skid.
  - On pop with the skid occupied, the skid moves to the head.
- Ordering:
  - tvalid = (out_cnt != 0). tdata = head.
  - tdata must be stable while tvalid & !tready.
  - Strict FIFO order; no loss or duplication.
- Latency: tvalid rises 2 cycles after the issue cycle. Minimum empty-to-tvalid is 3 cycles after the write pointer becomes visible at wq2_wptr.
- Throughput: with tready held high, one beat per cycle sustained.
- Wrap: r_addr goes from DEPTH_WIDTH-1 to 0. The MSB of rbin toggles. Full/empty disambiguation is done by the write side.
- Simultaneous events:
  - Pop, capture and issue in the same cycle are legal.
  - flush in the same cycle as capture or pop: flush wins, and the memory return is dropped.

Decomposition:
- fifo_pkg holds the bin2gray and gray2bin functions (parameterized by width), plus a localparam check that DEPTH_WIDTH == 2**PTR_WIDTH.
- One sub-module: fifo_sync_2ff (parameter WIDTH; ports r_clk, rreset, d, q). It is also reused by the write side.

Test Plan:
- Reset: rreset=1 for 2 cycles with random inputs -> m_axis_tvalid=0, empty=1, fifo_empty=1, rd_ptr_gray=0, r_addr=0, rd_level=0.
- Single beat:
  - Stimulus: wq_wptr_gray 00000->00001, tready=1, mem_data_out=0xA5 the cycle after the read.
  - Response: empty falls after sync, then one fifo_rd_enable with r_addr=0, then tvalid with tdata=0xA5 2 cycles after the issue. Finally rd_ptr_gray=00001 and empty=1.
- Full drain with wrap:
  - Stimulus: wq_wptr_gray=11000 (binary 16), tready=1.
  - Response: 16 back-to-back issues with r_addr 0..15, rd_level counts 16->0, 16 consecutive tvalid beats in order, final rd_ptr_gray=11000.
  - Continue with wq_wptr_gray=11001 -> r_addr=0, rd_ptr_gray=11001.
- Backpressure:
  - Stimulus: 4 entries (0x11..0x44), tready=0.
  - Response: exactly 2 reads issued, tvalid=1, tdata stays 0x11.
  - Then assert tready -> 0x11, 0x22, 0x33, 0x44 in order, no duplicates.
  - Then toggle tready every cycle -> order preserved.
- Flush mid-stream:
  - Stimulus: flush=1 for 1 cycle while tvalid=1 and inflight=1.
  - Response: next cycle tvalid=0, rd_ptr_gray=0, r_addr=0, fifo_empty=1; the late mem_data_out is ignored.
- Pointer sync: change wq_wptr_gray by one Gray step per cycle -> empty and rd_level track with exactly 2 sync cycles plus 1 register cycle of delay; no read is issued while empty=1.
